// File: rtl/multicycle_ctrl_sequencer_pkg.sv
// Shared encodings for the multi-cycle control sequencer: FSM states, opcodes,
// ALU operation codes, fault codes and the packed control word.
package selten_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALTED = 3'd6;
  localparam logic [2:0] ST_FAULT  = 3'd7;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h5;
  localparam logic [3:0] OP_ST   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_BNE  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_CALL = 4'hA;
  localparam logic [3:0] OP_RET  = 4'hB;
  localparam logic [3:0] OP_NOP  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hD;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_ILLEGAL  = 2'b01;
  localparam logic [1:0] FC_STACK    = 2'b10;
  localparam logic [1:0] FC_DMEM_TMO = 2'b11;

  typedef struct packed {
    logic       alu_src;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       is_ld;
    logic       is_st;
    logic       is_beq;
    logic       is_bne;
    logic       is_jmp;
    logic       is_call;
    logic       is_ret;
    logic       needs_wb;
  } ctrl_word_t;

endpackage

// File: rtl/multicycle_ctrl_sequencer_if.sv
// Datapath/memory-facing signal bundle of the sequencer; master is the sequencer side.
interface multicycle_ctrl_sequencer_if #(
  parameter int STACK_DEPTH = 16
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic            run;
  logic [3:0]      opcode;
  logic            imem_ready;
  logic            dmem_ready;
  logic            imem_req;
  logic            ir_load;
  logic            pc_write;
  logic            jump;
  logic            beq;
  logic            bne;
  logic            call;
  logic            ret;
  logic            mem_read;
  logic            mem_write;
  logic            alu_src;
  logic            reg_dst;
  logic            mem_to_reg;
  logic [1:0]      alu_op;
  logic            reg_write;
  logic [2:0]      state;
  logic            halted;
  logic            fault;
  logic [1:0]      fault_code;
  logic [SP_W-1:0] sp_depth;

  modport master (
    input  run, opcode, imem_ready, dmem_ready,
    output imem_req, ir_load, pc_write, jump, beq, bne, call, ret,
           mem_read, mem_write, alu_src, reg_dst, mem_to_reg, alu_op,
           reg_write, state, halted, fault, fault_code, sp_depth
  );

  modport slave (
    output run, opcode, imem_ready, dmem_ready,
    input  imem_req, ir_load, pc_write, jump, beq, bne, call, ret,
           mem_read, mem_write, alu_src, reg_dst, mem_to_reg, alu_op,
           reg_write, state, halted, fault, fault_code, sp_depth
  );
endinterface

// File: rtl/multicycle_ctrl_sequencer_ctrl_decoder.sv
// Combinational opcode decoder: control word plus illegal-opcode flag.
module ctrl_decoder
  import selten_ctrl_pkg::*;
(
  input  logic [3:0] i_opcode,
  output ctrl_word_t o_cw,
  output logic       o_illegal
);

  // Opcode to control word; E/F are the only unmapped encodings.
  always_comb begin
    o_cw      = '0;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        o_cw.reg_dst  = 1'b1;
        o_cw.alu_op   = ALU_FUNCT;
        o_cw.needs_wb = 1'b1;
      end
      OP_ADDI: begin
        o_cw.alu_src  = 1'b1;
        o_cw.alu_op   = ALU_ADD;
        o_cw.needs_wb = 1'b1;
      end
      OP_LD: begin
        o_cw.alu_src    = 1'b1;
        o_cw.mem_to_reg = 1'b1;
        o_cw.alu_op     = ALU_ADD;
        o_cw.is_ld      = 1'b1;
        o_cw.needs_wb   = 1'b1;
      end
      OP_ST: begin
        o_cw.alu_src = 1'b1;
        o_cw.alu_op  = ALU_ADD;
        o_cw.is_st   = 1'b1;
      end
      OP_BEQ: begin
        o_cw.alu_op = ALU_SUB;
        o_cw.is_beq = 1'b1;
      end
      OP_BNE: begin
        o_cw.alu_op = ALU_SUB;
        o_cw.is_bne = 1'b1;
      end
      OP_JMP:           o_cw.is_jmp  = 1'b1;
      OP_CALL:          o_cw.is_call = 1'b1;
      OP_RET:           o_cw.is_ret  = 1'b1;
      OP_NOP, OP_HALT:  o_cw         = '0;
      default:          o_illegal    = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with call-depth tracking and
// sticky HALTED/FAULT states.
module multicycle_ctrl_sequencer
  import selten_ctrl_pkg::*;
#(
  parameter int STACK_DEPTH = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input logic                         clk,
  input logic                         rst_n,
  multicycle_ctrl_sequencer_if.master bus
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [SP_W-1:0]  SP_MAX  = SP_W'(STACK_DEPTH);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MEM_TIMEOUT);

  logic [2:0]       r_state, w_state_nxt, w_end_state;
  ctrl_word_t       r_cw, w_dec_cw, w_lvl_cw;
  logic             w_illegal;
  logic [SP_W-1:0]  r_sp_depth, w_sp_nxt;
  logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
  logic [1:0]       r_fault_code, w_fc_nxt;
  logic             w_sp_full, w_sp_empty, w_in_exec, w_in_mem;

  ctrl_decoder u_dec (
    .i_opcode  (bus.opcode),
    .o_cw      (w_dec_cw),
    .o_illegal (w_illegal)
  );

  assign w_end_state = bus.run ? ST_FETCH : ST_IDLE;
  assign w_sp_full   = (r_sp_depth == SP_MAX);
  assign w_sp_empty  = (r_sp_depth == SP_W'(0));
  assign w_in_exec   = (r_state == ST_EXEC);
  assign w_in_mem    = (r_state == ST_MEM);

  // Next-state, call depth, timeout counter and fault code.
  always_comb begin
    w_state_nxt = r_state;
    w_sp_nxt    = r_sp_depth;
    w_tmo_nxt   = r_tmo;
    w_fc_nxt    = r_fault_code;
    case (r_state)
      ST_IDLE: begin
        if (bus.run) w_state_nxt = ST_FETCH;
        else         w_state_nxt = ST_IDLE;
      end
      ST_FETCH: begin
        if (bus.imem_ready) w_state_nxt = ST_DECODE;
        else                w_state_nxt = ST_FETCH;
      end
      ST_DECODE: begin
        if (w_illegal) begin
          w_state_nxt = ST_FAULT;
          w_fc_nxt    = FC_ILLEGAL;
        end else if (bus.opcode == OP_HALT) begin
          w_state_nxt = ST_HALTED;
        end else begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_tmo_nxt = TMO_W'(0);
        if ((r_cw.is_call && w_sp_full) || (r_cw.is_ret && w_sp_empty)) begin
          w_state_nxt = ST_FAULT;
          w_fc_nxt    = FC_STACK;
        end else begin
          if (r_cw.is_call)     w_sp_nxt = r_sp_depth + SP_W'(1);
          else if (r_cw.is_ret) w_sp_nxt = r_sp_depth - SP_W'(1);
          else                  w_sp_nxt = r_sp_depth;
          if (r_cw.is_ld || r_cw.is_st) w_state_nxt = ST_MEM;
          else if (r_cw.needs_wb)       w_state_nxt = ST_WB;
          else                          w_state_nxt = w_end_state;
        end
      end
      ST_MEM: begin
        // A ready on the limit cycle still wins over the timeout.
        if (bus.dmem_ready) begin
          w_tmo_nxt   = TMO_W'(0);
          w_state_nxt = r_cw.is_ld ? ST_WB : w_end_state;
        end else if (r_tmo == TMO_MAX) begin
          w_state_nxt = ST_FAULT;
          w_fc_nxt    = FC_DMEM_TMO;
        end else begin
          w_tmo_nxt = r_tmo + TMO_W'(1);
        end
      end
      ST_WB:     w_state_nxt = w_end_state;
      ST_HALTED: w_state_nxt = ST_HALTED;
      ST_FAULT:  w_state_nxt = ST_FAULT;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Sequencer state registers; the control word is captured during DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cw         <= '0;
      r_sp_depth   <= SP_W'(0);
      r_tmo        <= TMO_W'(0);
      r_fault_code <= FC_NONE;
    end else begin
      r_state      <= w_state_nxt;
      r_sp_depth   <= w_sp_nxt;
      r_tmo        <= w_tmo_nxt;
      r_fault_code <= w_fc_nxt;
      if (r_state == ST_DECODE) r_cw <= w_dec_cw;
      else                      r_cw <= r_cw;
    end
  end

  // Decode drives the levels combinationally in DECODE, the latched word thereafter.
  assign w_lvl_cw = (r_state == ST_DECODE) ? w_dec_cw :
                    ((r_state == ST_EXEC) || (r_state == ST_MEM) || (r_state == ST_WB)) ? r_cw :
                    ctrl_word_t'('0);

  assign bus.imem_req   = (r_state == ST_FETCH);
  assign bus.ir_load    = (r_state == ST_FETCH) && bus.imem_ready;
  assign bus.pc_write   = (r_state == ST_FETCH) && bus.imem_ready;
  assign bus.jump       = w_in_exec && r_cw.is_jmp;
  assign bus.beq        = w_in_exec && r_cw.is_beq;
  assign bus.bne        = w_in_exec && r_cw.is_bne;
  assign bus.call       = w_in_exec && r_cw.is_call && !w_sp_full;
  assign bus.ret        = w_in_exec && r_cw.is_ret && !w_sp_empty;
  assign bus.mem_read   = w_in_mem && r_cw.is_ld;
  assign bus.mem_write  = w_in_mem && r_cw.is_st;
  assign bus.alu_src    = w_lvl_cw.alu_src;
  assign bus.reg_dst    = w_lvl_cw.reg_dst;
  assign bus.mem_to_reg = w_lvl_cw.mem_to_reg;
  assign bus.alu_op     = w_lvl_cw.alu_op;
  assign bus.reg_write  = (r_state == ST_WB);
  assign bus.state      = r_state;
  assign bus.halted     = (r_state == ST_HALTED);
  assign bus.fault      = (r_state == ST_FAULT);
  assign bus.fault_code = r_fault_code;
  assign bus.sp_depth   = r_sp_depth;

endmodule
